// File: rtl/ham_secded_stream_decoder_pkg.sv
// Shared definitions for the Hamming SEC/SEC-DED stream decoder.
// Provides code-geometry helpers (ham_n, ham_k), the power-of-two test
// that separates parity positions from data positions, the data-bit to
// position mapping, a per-bit syndrome function and the status encoding.
package ham_pkg;

    localparam int unsigned MAX_R = 6;
    localparam int unsigned MAX_N = 63;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'd0,
        ST_SINGLE = 2'd1,
        ST_DOUBLE = 2'd2
    } status_t;

    function automatic int unsigned ham_n(input int unsigned r);
        return (32'd1 << r) - 32'd1;
    endfunction

    function automatic int unsigned ham_k(input int unsigned r);
        return ham_n(r) - r;
    endfunction

    function automatic bit is_pow2(input int unsigned x);
        return (x != 0) && ((x & (x - 32'd1)) == 0);
    endfunction

    // 0-based codeword index of data bit j (data bits fill the
    // non-power-of-two positions in ascending order).
    function automatic int unsigned data_pos(input int unsigned j);
        int unsigned pos;
        int unsigned cnt;
        pos = 0;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (!is_pow2(i + 1)) begin
                if (cnt == j) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Bit b of the syndrome: parity over every set position whose
    // 1-based index has bit b set.
    function automatic logic ham_syn_bit(input logic [MAX_N-1:0] code,
                                         input int unsigned b);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if ((((i + 1) >> b) & 32'd1) != 0) r ^= code[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ham_secded_stream_decoder_if.sv
// Codeword-in / data-out handshake bundle for the stream decoder.
//   in_valid/in_ready/in_code    : codeword stream (N+SECDED bits)
//   out_valid/out_ready          : decoded word stream
//   out_data, out_syndrome       : K data bits, R-bit syndrome
//   out_err_single/out_err_double: error classification flags
// Modport slave is the decoder side, master is the producer/consumer side.
interface ham_secded_stream_decoder_if
    import ham_pkg::*;
#(
    parameter int unsigned R      = 4,
    parameter int unsigned SECDED = 1
);
    localparam int unsigned N = ham_n(R);
    localparam int unsigned K = ham_k(R);

    logic                  in_valid;
    logic                  in_ready;
    logic [N+SECDED-1:0]   in_code;
    logic                  out_valid;
    logic                  out_ready;
    logic [K-1:0]          out_data;
    logic [R-1:0]          out_syndrome;
    logic                  out_err_single;
    logic                  out_err_double;

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_syndrome,
               out_err_single, out_err_double
    );

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_syndrome,
               out_err_single, out_err_double
    );
endinterface

// File: rtl/ham_secded_stream_decoder_syndrome.sv
// Combinational syndrome / overall-parity generator.
//   code : N+SECDED codeword, code[i] is Hamming position i+1
//   s    : R-bit syndrome (XOR of positions of all set bits)
//   p    : overall parity when SECDED=1; |s when SECDED=0
module ham_syndrome
    import ham_pkg::*;
#(
    parameter int unsigned R      = 4,
    parameter int unsigned SECDED = 1
) (
    input  logic [ham_n(R)+SECDED-1:0] code,
    output logic [R-1:0]               s,
    output logic                       p
);
    localparam int unsigned N = ham_n(R);

    logic [MAX_N-1:0] padded;

    always_comb begin
        padded        = '0;
        padded[N-1:0] = code[N-1:0];
        for (int unsigned b = 0; b < R; b++) begin
            s[b] = ham_syn_bit(padded, b);
        end
        p = (SECDED != 0) ? ^code : |s;
    end
endmodule

// File: rtl/ham_secded_stream_decoder.sv
// Two-stage pipelined Hamming(2^R-1) SEC / SEC-DED stream decoder.
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : codeword in / decoded word out handshakes
//   cnt_clr           : synchronous clear of both counters (beats increment)
//   cnt_corrected     : saturating count of delivered words with err_single
//   cnt_uncorrectable : saturating count of delivered words with err_double
module ham_secded_stream_decoder
    import ham_pkg::*;
#(
    parameter int unsigned R      = 4,
    parameter int unsigned SECDED = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ham_secded_stream_decoder_if.slave bus,
    input  logic                       cnt_clr,
    output logic [CNT_W-1:0]           cnt_corrected,
    output logic [CNT_W-1:0]           cnt_uncorrectable
);
    localparam int unsigned K = ham_k(R);

    logic [R-1:0] syn_s;
    logic         syn_p;
    logic [K-1:0] in_data;

    logic         s1_valid;
    logic [K-1:0] s1_data;
    logic [R-1:0] s1_syn;
    logic         s1_par;

    logic         s2_valid;
    logic [K-1:0] s2_data;
    logic [R-1:0] s2_syn;
    logic         s2_single;
    logic         s2_double;

    logic         s1_load;
    logic         s2_load;
    logic         out_fire;
    logic         flip;
    status_t      status;
    logic [K-1:0] fixed_data;

    ham_syndrome #(.R(R), .SECDED(SECDED)) u_syndrome (
        .code (bus.in_code),
        .s    (syn_s),
        .p    (syn_p)
    );

    assign s2_load  = !s2_valid || bus.out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign out_fire = s2_valid && bus.out_ready;

    // Stage 1 keeps only the data positions of the codeword; correction
    // in stage 2 is applied by matching each data bit's position against S.
    always_comb begin
        in_data = '0;
        for (int unsigned j = 0; j < K; j++) begin
            in_data[j] = bus.in_code[data_pos(j)];
        end
    end

    // With SECDED=0 the syndrome block reports p=|s, so the same decision
    // tree yields single-only classification and never flags double.
    always_comb begin
        flip   = 1'b0;
        status = ST_CLEAN;
        if (s1_par) begin
            status = ST_SINGLE;
            flip   = (s1_syn != '0);
        end else if (s1_syn != '0) begin
            status = ST_DOUBLE;
        end
        fixed_data = '0;
        for (int unsigned j = 0; j < K; j++) begin
            fixed_data[j] = s1_data[j] ^ (flip && (s1_syn == R'(data_pos(j) + 1)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_syn    <= '0;
            s1_par    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_syn    <= '0;
            s2_single <= 1'b0;
            s2_double <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                s1_data  <= in_data;
                s1_syn   <= syn_s;
                s1_par   <= syn_p;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data   <= fixed_data;
                    s2_syn    <= s1_syn;
                    s2_single <= (status == ST_SINGLE);
                    s2_double <= (status == ST_DOUBLE);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_corrected     <= '0;
            cnt_uncorrectable <= '0;
        end else begin
            if (out_fire && s2_single && (cnt_corrected != '1))
                cnt_corrected <= cnt_corrected + CNT_W'(1);
            if (out_fire && s2_double && (cnt_uncorrectable != '1))
                cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
        end
    end

    assign bus.in_ready       = s1_load;
    assign bus.out_valid      = s2_valid;
    assign bus.out_data       = s2_data;
    assign bus.out_syndrome   = s2_syn;
    assign bus.out_err_single = s2_single;
    assign bus.out_err_double = s2_double;
endmodule

// File: tb/tb_ham_secded_stream_decoder.sv
// Scoreboard bench for ham_secded_stream_decoder.
// Three instances: A (R=4, SECDED=1, CNT_W=16), B (R=4, SECDED=1, CNT_W=2)
// and C (R=3, SECDED=0, CNT_W=16). Stimulus pushes hand-computed expected
// words into per-instance queues; negedge monitors pop and compare.
module tb_ham_secded_stream_decoder;
    import ham_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
    logic [15:0] cnt_ca, cnt_ua, cnt_cc, cnt_uc;
    logic [1:0]  cnt_cb, cnt_ub;

    ham_secded_stream_decoder_if #(.R(4), .SECDED(1)) bus_a ();
    ham_secded_stream_decoder_if #(.R(4), .SECDED(1)) bus_b ();
    ham_secded_stream_decoder_if #(.R(3), .SECDED(0)) bus_c ();

    ham_secded_stream_decoder #(.R(4), .SECDED(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .cnt_clr(clr_a),
        .cnt_corrected(cnt_ca), .cnt_uncorrectable(cnt_ua)
    );
    ham_secded_stream_decoder #(.R(4), .SECDED(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .cnt_clr(clr_b),
        .cnt_corrected(cnt_cb), .cnt_uncorrectable(cnt_ub)
    );
    ham_secded_stream_decoder #(.R(3), .SECDED(0), .CNT_W(16)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c), .cnt_clr(clr_c),
        .cnt_corrected(cnt_cc), .cnt_uncorrectable(cnt_uc)
    );

    typedef struct {
        logic [10:0] data;
        logic [3:0]  syn;
        logic        sgl;
        logic        dbl;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit stall_seen = 0;

    logic [15:0] t4_code [8] = '{16'h0000, 16'hFFFF, 16'h8007, 16'h8019,
                                 16'hC08B, 16'h001E, 16'h408C, 16'h4092};
    logic [10:0] t4_data [8] = '{11'h000, 11'h7FF, 11'h001, 11'h002,
                                 11'h400, 11'h003, 11'h401, 11'h402};
    bit          t4_rdy  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic exp_t mk(input logic [10:0] d, input logic [3:0] s,
                                input logic sg, input logic db, input bit lat);
        exp_t e;
        e.data = d;
        e.syn  = s;
        e.sgl  = sg;
        e.dbl  = db;
        e.cyc  = 0;
        e.lat  = lat;
        return e;
    endfunction

    function automatic void score(input string nm, input exp_t e,
                                  input logic [10:0] d, input logic [3:0] s,
                                  input logic sg, input logic db);
        chk({nm, " data"}, 32'(d), 32'(e.data));
        chk({nm, " syndrome"}, 32'(s), 32'(e.syn));
        chk({nm, " err_single"}, 32'(sg), 32'(e.sgl));
        chk({nm, " err_double"}, 32'(db), 32'(e.dbl));
        if (e.lat) chk({nm, " latency"}, 32'(cyc - e.cyc), 32'd2);
    endfunction

    // Monitor A also checks that a stalled output does not change.
    logic        held_a = 1'b0;
    logic [16:0] held_val;
    logic [16:0] cur_a;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_a = 1'b0;
        end else begin
            cur_a = {bus_a.out_data, bus_a.out_syndrome,
                     bus_a.out_err_single, bus_a.out_err_double};
            if (held_a && bus_a.out_valid)
                chk("A stall stable", 32'(cur_a), 32'(held_val));
            held_a   = bus_a.out_valid && !bus_a.out_ready;
            held_val = cur_a;
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (qa.size() == 0) chk("A unexpected output", 32'd1, 32'd0);
                else score("A", qa.pop_front(), bus_a.out_data, bus_a.out_syndrome,
                           bus_a.out_err_single, bus_a.out_err_double);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
            if (qb.size() == 0) chk("B unexpected output", 32'd1, 32'd0);
            else score("B", qb.pop_front(), bus_b.out_data, bus_b.out_syndrome,
                       bus_b.out_err_single, bus_b.out_err_double);
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_c.out_valid && bus_c.out_ready) begin
            if (qc.size() == 0) chk("C unexpected output", 32'd1, 32'd0);
            else score("C", qc.pop_front(), {7'b0, bus_c.out_data},
                       {1'b0, bus_c.out_syndrome},
                       bus_c.out_err_single, bus_c.out_err_double);
        end
    end

    task automatic set_in(input int w, input logic v, input logic [15:0] code);
        case (w)
            0: begin bus_a.in_valid = v; bus_a.in_code = code; end
            1: begin bus_b.in_valid = v; bus_b.in_code = code; end
            default: begin bus_c.in_valid = v; bus_c.in_code = code[6:0]; end
        endcase
    endtask

    task automatic send(input int w, input logic [15:0] code, input exp_t e);
        int   waited;
        logic rdy;
        waited = 0;
        rdy    = 1'b0;
        set_in(w, 1'b1, code);
        forever begin
            @(negedge clk);
            rdy = (w == 0) ? bus_a.in_ready : (w == 1) ? bus_b.in_ready : bus_c.in_ready;
            if (rdy) break;
            stall_seen = 1;
            waited++;
            if (waited > 50) break;
            @(posedge clk);
            #1;
        end
        if (rdy) begin
            e.cyc = cyc;
            case (w)
                0: qa.push_back(e);
                1: qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end else begin
            chk("send in_ready timeout", 32'd1, 32'd0);
        end
        @(posedge clk);
        #1;
        set_in(w, 1'b0, code);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("drain pending words", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 1'b0, 16'h0);
        set_in(1, 1'b0, 16'h0);
        set_in(2, 1'b0, 16'h0);
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_c.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("reset out_data", 32'(bus_a.out_data), 32'd0);
        chk("reset cnt_corrected", 32'(cnt_ca), 32'd0);
        chk("reset in_ready", 32'(bus_a.in_ready), 32'd1);
        rst_n = 1'b1;

        // Clean words
        send(0, 16'h0000, mk(11'h000, 4'd0, 1'b0, 1'b0, 1'b1));
        send(0, 16'hFFFF, mk(11'h7FF, 4'd0, 1'b0, 1'b0, 1'b1));
        drain();
        chk("t1 cnt_corrected", 32'(cnt_ca), 32'd0);
        chk("t1 cnt_uncorrectable", 32'(cnt_ua), 32'd0);

        // Single errors corrected
        send(0, 16'h0010, mk(11'h000, 4'd5, 1'b1, 1'b0, 1'b1));
        send(0, 16'hFDFF, mk(11'h7FF, 4'd10, 1'b1, 1'b0, 1'b1));
        drain();
        chk("t2 cnt_corrected", 32'(cnt_ca), 32'd2);
        chk("t2 cnt_uncorrectable", 32'(cnt_ua), 32'd0);

        clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        chk("clr cnt_corrected", 32'(cnt_ca), 32'd0);

        // Double error and extended-bit error
        send(0, 16'h0011, mk(11'h002, 4'd4, 1'b0, 1'b1, 1'b1));
        send(0, 16'h8000, mk(11'h000, 4'd0, 1'b1, 1'b0, 1'b1));
        drain();
        chk("t3 cnt_uncorrectable", 32'(cnt_ua), 32'd1);
        chk("t3 cnt_corrected", 32'(cnt_ca), 32'd1);

        // Backpressure stream
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(0, t4_code[i], mk(t4_data[i], 4'd0, 1'b0, 1'b0, 1'b0));
            end
            begin
                for (int k = 0; k < 32; k++) begin
                    bus_a.out_ready = t4_rdy[k % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus_a.out_ready = 1'b1;
        drain();
        chk("t4 in_ready dropped", 32'(stall_seen), 32'd1);
        chk("t4 cnt_corrected unchanged", 32'(cnt_ca), 32'd1);

        // Saturation with CNT_W=2, then clear beating an increment
        for (int i = 0; i < 5; i++)
            send(1, 16'h0010, mk(11'h000, 4'd5, 1'b1, 1'b0, 1'b1));
        drain();
        chk("t5 saturated", 32'(cnt_cb), 32'd3);
        send(1, 16'hFDFF, mk(11'h7FF, 4'd10, 1'b1, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        chk("t5 out_valid at clr", 32'(bus_b.out_valid), 32'd1);
        clr_b = 1'b1;
        @(posedge clk);
        #1;
        clr_b = 1'b0;
        chk("t5 clr beats increment", 32'(cnt_cb), 32'd0);
        chk("t5 queue consumed", 32'(qb.size()), 32'd0);

        // Reset with both stages full
        bus_a.out_ready = 1'b0;
        send(0, 16'h8007, mk(11'h001, 4'd0, 1'b0, 1'b0, 1'b0));
        send(0, 16'h8019, mk(11'h002, 4'd0, 1'b0, 1'b0, 1'b0));
        chk("t6 full in_ready", 32'(bus_a.in_ready), 32'd0);
        chk("t6 full out_valid", 32'(bus_a.out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete();
        chk("t6 out_valid after reset", 32'(bus_a.out_valid), 32'd0);
        chk("t6 cnt_corrected after reset", 32'(cnt_ca), 32'd0);
        chk("t6 cnt_uncorrectable after reset", 32'(cnt_ua), 32'd0);
        chk("t6 in_ready after reset", 32'(bus_a.in_ready), 32'd1);
        bus_a.out_ready = 1'b1;
        send(0, 16'hC08B, mk(11'h400, 4'd0, 1'b0, 1'b0, 1'b1));
        drain();

        // R=3 plain SEC
        send(2, 16'h0010, mk(11'h000, 4'd5, 1'b1, 1'b0, 1'b1));
        send(2, 16'h005F, mk(11'h00F, 4'd6, 1'b1, 1'b0, 1'b1));
        drain();
        chk("t7 cnt_corrected", 32'(cnt_cc), 32'd2);
        chk("t7 cnt_uncorrectable", 32'(cnt_uc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
